dice_roll_sequencer: RTL

DICE_ROLL_SEQUENCER -- requirements
Module: dice_roll_sequencer

---
 rtl/dice_roll_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dice_roll_sequencer.sv
// ============================================================================
// Module  : dice_roll_sequencer
// Brief   : LFSR-driven five-die roll sequencer with hold mask and optional
//           shuffle animation (enable with DICE_ANIM_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dice_roll_sequencer #(
  parameter int          ANIM_STEPS = 8,
  parameter int          STEP_DIV   = 4,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        roll_trigger,
  input  logic        dice_clear,
  input  logic [4:0]  hold_sw,
  input  logic [1:0]  roll_cnt,
  output logic [14:0] dice_vals,
  output logic [4:0]  dice_sum,
  output logic        busy,
  output logic        roll_done,
  output logic        dice_valid
);

`ifdef DICE_ANIM_EN
  localparam bit c_anim_en = 1'b1;
`else
  localparam bit c_anim_en = 1'b0;
`endif

  localparam int          c_steps     = c_anim_en ? ANIM_STEPS : 1;
  localparam int          c_div       = c_anim_en ? STEP_DIV : 1;
  localparam logic [7:0]  c_step_last = 8'(c_steps - 1);
  localparam logic [15:0] c_div_last  = 16'(c_div - 1);
  localparam logic [15:0] c_seed      = (SEED == 16'h0000) ? 16'hACE1 : SEED;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHUFFLE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_lfsr;
  logic [14:0] r_vals;
  logic [4:0]  r_sum;
  logic [4:0]  r_mask;
  logic [7:0]  r_step;
  logic [15:0] r_div;
  logic        r_busy;
  logic        r_done;
  logic        r_valid;

  logic [15:0] w_lfsr_next;
  logic [14:0] w_new_vals;
  logic [4:0]  w_new_sum;
  logic [4:0]  w_trig_mask;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Fibonacci form
  assign w_lfsr_next = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

  for (genvar i = 0; i < 5; i++) begin : g_die
    logic [2:0] w_field;
    logic [2:0] w_rand;
    assign w_field = r_lfsr[3*i +: 3];
    // (f mod 6) + 1 over a 3-bit field: 0..5 -> 1..6, 6 -> 1, 7 -> 2
    assign w_rand  = (w_field >= 3'd6) ? (w_field - 3'd5) : (w_field + 3'd1);
    assign w_new_vals[3*i +: 3] = r_mask[i] ? w_rand : r_vals[3*i +: 3];
    // Blank dice are always rolled, even when held
    assign w_trig_mask[i] = (roll_cnt == 2'd0) || !hold_sw[i] ||
                            (r_vals[3*i +: 3] == 3'd0);
  end

  always_comb begin
    w_new_sum = 5'd0;
    for (int i = 0; i < 5; i++) begin
      w_new_sum = w_new_sum + {2'b00, w_new_vals[3*i +: 3]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_lfsr  <= c_seed;
      r_vals  <= 15'd0;
      r_sum   <= 5'd0;
      r_mask  <= 5'd0;
      r_step  <= 8'd0;
      r_div   <= 16'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_lfsr <= w_lfsr_next;
      r_done <= 1'b0;
      if (dice_clear) begin
        r_state <= ST_IDLE;
        r_vals  <= 15'd0;
        r_sum   <= 5'd0;
        r_step  <= 8'd0;
        r_div   <= 16'd0;
        r_busy  <= 1'b0;
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (roll_trigger) begin
              r_state <= ST_SHUFFLE;
              r_busy  <= 1'b1;
              r_valid <= 1'b0;
              r_mask  <= w_trig_mask;
              r_step  <= 8'd0;
              r_div   <= 16'd0;
            end
          end
          ST_SHUFFLE: begin
            if (r_div == c_div_last) begin
              r_div  <= 16'd0;
              r_vals <= w_new_vals;
              if (r_step == c_step_last) begin
                r_state <= ST_DONE;
                r_step  <= 8'd0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_valid <= 1'b1;
                r_sum   <= w_new_sum;
              end else begin
                r_step <= r_step + 8'd1;
              end
            end else begin
              r_div <= r_div + 16'd1;
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign dice_vals  = r_vals;
  assign dice_sum   = r_sum;
  assign busy       = r_busy;
  assign roll_done  = r_done;
  assign dice_valid = r_valid;

endmodule

`default_nettype wire
